// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  function automatic logic is_div(op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic b_signed(op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage control and the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  op_e             OP;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] y;

  modport master (output start, OP, a, b, input busy, done, y);
  modport slave  (input start, OP, a, b, output busy, done, y);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide over magnitudes,
// with sign correction applied when the result is loaded into y.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  state_e            state_q;
  op_e               op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic              neg_q;
  logic              a_neg_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   y_q;

  op_e             op_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_y;

  always_comb begin
    op_in    = bus.OP;
    a_neg_in = a_signed(op_in) & bus.a[XLEN-1];
    b_neg_in = b_signed(op_in) & bus.b[XLEN-1];
    a_mag    = a_neg_in ? -bus.a : bus.a;
    b_mag    = b_neg_in ? -bus.b : bus.b;
    div_zero = is_div(op_in) && (bus.b == '0);
    div_ovf  = ((op_in == OpDiv) || (op_in == OpRem)) &&
               (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    // op bit 1 distinguishes REM/REMU from DIV/DIVU
    if (div_zero) begin
      special_y = op_in[1] ? bus.a : '1;
    end else begin
      special_y = op_in[1] ? '0 : bus.a;
    end
  end

  // acc_q: multiply = {partial product, remaining multiplier bits};
  //        divide   = {partial remainder, dividend bits shifting into quotient}
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!is_div(op_q)) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (div_diff[XLEN]) begin
      acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = a_neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OpMul:                     result = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: result = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             result = quo_fix;
      default:                   result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpMul;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= op_in;
            neg_q   <= a_neg_in ^ b_neg_in;
            a_neg_q <= a_neg_in;
            busy_q  <= 1'b1;
            if (div_zero || div_ovf) begin
              y_q     <= special_y;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, a_mag};
              opb_q   <= b_mag;
              cnt_q   <= CW'(XLEN);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            y_q     <= result;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a 64-bit model,
// and hand-written sequences for restart, held start and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   check_cnt;
  int   pass_cnt;
  logic [31:0] exp_q[$];

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("y_on_done", bus.y, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] ref_model(input op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OpMul:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0];  end
      OpMulh:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      OpMulhsu: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
      OpMulhu:  begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
      OpDiv:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op, scrambles operands while busy, checks busy, latency and hold of y.
  task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_y, input int exp_lat);
    int n;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.OP    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(exp_y);
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_while_active", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("y_held", bus.y, exp_y);
  endtask

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    bit seen;
    op_e rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{OpMulh,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{OpMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{OpMulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{OpDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{OpRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{OpDivu,   32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{OpRemu,   32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{OpDivu,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{OpRem,    32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{OpDiv,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{OpRem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

    check_cnt = 0;
    pass_cnt  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.OP    = OpMul;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_y", bus.y, 32'd0);

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat);

    for (int i = 0; i < 8; i++) begin
      rop = op_e'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      do_op(rop, ra, rb, ref_model(rop, ra, rb),
            (is_div(rop) && rb == 0) ? 1 : 33);
    end

    // Second start pulse with new operands while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.OP    = OpMul;
    bus.a     = 32'd7;
    bus.b     = 32'hFFFF_FFFD;
    exp_q.push_back(32'hFFFF_FFEB);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      bus.start = (n == 10);
      if (n == 10) begin
        bus.a = 32'd2;
        bus.b = 32'd3;
      end
      if (bus.done) seen = 1'b1;
    end
    check("restart_ignored_latency", 32'(n), 32'd33);
    repeat (40) @(negedge clk);
    check("restart_no_extra_done", 32'(exp_q.size()), 32'd0);

    // Start held high through done: next op accepted in the cycle after done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.OP    = OpDivu;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    exp_q.push_back(32'd14);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check("held_first_latency", 32'(n), 32'd33);
    bus.OP = OpMul;
    bus.a  = 32'd6;
    bus.b  = 32'd7;
    exp_q.push_back(32'd42);
    @(negedge clk);
    check("held_idle_gap_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("held_accepted_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    n = 2;
    seen = 1'b0;
    while (n < 45 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check("held_second_gap", 32'(n), 32'd34);

    // Reset during a divide aborts it without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.OP    = OpDivu;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_y", bus.y, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    do_op(OpRemu, 32'd100, 32'd7, 32'd2, 33);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
- Takes the same rs1/rs2 operands the ALU receives.
- Its result is muxed with the ALU result ahead of writeback.
- Control stalls the PC/regfile write while busy is high and captures y when done pulses.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- OP  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand
- b  input  XLEN  rs2 operand
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; y valid
- y  output  XLEN  result; held from done until the next accepted start

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset value of all outputs: busy=0, done=0, y=0. State=IDLE. Counter and datapath registers are cleared.
- Reset mid-operation aborts the operation. No done pulse. The unit is in IDLE on the next cycle.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge k:
  - Latch OP, a and b.
  - Compute operand magnitudes and result sign:
    - a signed for MULH, MULHSU, DIV, REM.
    - b signed for MULH, DIV, REM.
  - Special case → DONE directly; done is high during cycle k+1.
  - Otherwise → CALC, counter=XLEN.
- CALC, multiply: radix-2 shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC duration: counter decrements each cycle. At 0 → DONE, so CALC lasts exactly XLEN cycles.
- DONE:
  - Apply sign correction and load y. Two's-complement negate of the product if the operand signs differ.
  - Quotient negated if a/b signs differ; remainder takes a's sign.
  - Result selection: MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits.
  - done=1 for exactly one cycle, then → IDLE.
- Latency: done asserted in cycle k+XLEN+1 (33 cycles for RV32) for normal ops.
- busy: high in CALC and DONE, low in IDLE.
- start while busy is ignored. Operand changes while busy are ignored (latched copy used).
- start in the cycle done is high is ignored, because the state is DONE, not IDLE. Accepted the next cycle.
- Special cases (1-cycle path, RISC-V semantics):
  - Divide by zero: DIV/DIVU y=all ones; REM/REMU y=a.
  - Signed overflow (a=0x80000000, b=all ones): DIV y=0x80000000; REM y=0.
  - Multiplies have no special cases.
- Arithmetic widths:
  - Magnitude of the most negative value is 2^(XLEN-1), held in XLEN bits as unsigned.
  - Product register is 2*XLEN.
  - Partial remainder is XLEN+1 bits (carry of the trial subtract).
- y changes only on reset or in the DONE state.

Decomposition:
- Package muldiv_pkg:
  - Enum for the 8 funct3 op codes.
  - State enum (IDLE/CALC/DONE).
  - Helper functions is_div(op), a_signed(op), b_signed(op).
- No sub-module required. Datapath and FSM live in one module; the unsigned core is small.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), start at cycle 0 → busy cycles 1-33, done at cycle 33, y=0xFFFFFFEB; y held until next start.
- MULH a=b=0x80000000 → y=0x40000000. MULHU a=b=0xFFFFFFFF → y=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → y=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → y=0xFFFFFFFD. REM same operands → y=0xFFFFFFFF. DIVU a=100, b=7 → y=14. REMU → y=2.
- DIVU a=5, b=0 → done at cycle 1, y=0xFFFFFFFF. REM a=5, b=0 → y=5. DIV a=0x80000000, b=0xFFFFFFFF → done at cycle 1, y=0x80000000. REM same operands → y=0.
- Start MUL, pulse start again with new operands at cycle 10 → ignored, original result delivered at cycle 33. Start held high through done → next op accepted the cycle after done; result correct.
- Start DIVU, assert reset at cycle 15 → cycle 16 busy=0, done=0, y=0. No done pulse later. Fresh start afterwards completes normally.
